riscv_demux5: RTL and testbench

Registered 1-to-5 result dispatcher for the RISC-V core, the distribution counterpart of the 5-way operand/result selectors. It accepts one result per cycle on a valid/ready handshake, tagged with a 3-bit destination select, and delivers it one cycle later to exactly one of five destination channels, each with its own valid/ready pair. A single-entry output slot provides back-pressure. Out-of-range selects are consumed and counted, never delivered. A synchronous flush discards in-flight data on pipeline redirect.

---
 rtl/riscv_demux5.sv | 104 ++++++++++
 tb/tb_riscv_demux5.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_demux5.sv
// Registered 1-to-5 result dispatcher with a single-entry output slot.
// Illegal selects are consumed, flagged and counted, never delivered.
module riscv_demux5 #(
    parameter int WIDTH = 64
) (
    input  logic             i_riscv_demux5_clk,
    input  logic             i_riscv_demux5_rst,
    input  logic             i_riscv_demux5_flush,
    input  logic             i_riscv_demux5_valid,
    input  logic [2:0]       i_riscv_demux5_sel,
    input  logic [WIDTH-1:0] i_riscv_demux5_in,
    output logic             o_riscv_demux5_ready,
    output logic [WIDTH-1:0] o_riscv_demux5_out0,
    output logic [WIDTH-1:0] o_riscv_demux5_out1,
    output logic [WIDTH-1:0] o_riscv_demux5_out2,
    output logic [WIDTH-1:0] o_riscv_demux5_out3,
    output logic [WIDTH-1:0] o_riscv_demux5_out4,
    output logic [4:0]       o_riscv_demux5_valid,
    input  logic [4:0]       i_riscv_demux5_ready,
    output logic             o_riscv_demux5_err,
    output logic [7:0]       o_riscv_demux5_drop_cnt
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       sel_q, sel_d;
    logic             err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;

    logic full;
    logic out_fire;
    logic in_fire;
    logic legal;

    assign full     = (state_q == S_FULL);
    assign out_fire = full && i_riscv_demux5_ready[sel_q];
    assign legal    = (i_riscv_demux5_sel <= 3'd4);

    // A full slot can take a new entry only while its own channel drains.
    assign o_riscv_demux5_ready = !i_riscv_demux5_flush
                                  && (!full || out_fire);
    assign in_fire = i_riscv_demux5_valid && o_riscv_demux5_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (i_riscv_demux5_flush) begin
            state_d = S_EMPTY;
        end else begin
            if (in_fire && legal) begin
                state_d = S_FULL;
                data_d  = i_riscv_demux5_in;
                sel_d   = i_riscv_demux5_sel;
            end else if (out_fire) begin
                state_d = S_EMPTY;
            end
            if (in_fire && !legal) begin
                err_d = 1'b1;
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge i_riscv_demux5_clk or posedge i_riscv_demux5_rst) begin
        if (i_riscv_demux5_rst) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        o_riscv_demux5_valid = '0;
        for (int k = 0; k < 5; k++) begin
            o_riscv_demux5_valid[k] = full && (sel_q == 3'(k));
        end
    end

    assign o_riscv_demux5_out0 = o_riscv_demux5_valid[0] ? data_q : '0;
    assign o_riscv_demux5_out1 = o_riscv_demux5_valid[1] ? data_q : '0;
    assign o_riscv_demux5_out2 = o_riscv_demux5_valid[2] ? data_q : '0;
    assign o_riscv_demux5_out3 = o_riscv_demux5_valid[3] ? data_q : '0;
    assign o_riscv_demux5_out4 = o_riscv_demux5_valid[4] ? data_q : '0;

    assign o_riscv_demux5_err      = err_q;
    assign o_riscv_demux5_drop_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_demux5.sv
// Self-checking bench for riscv_demux5: directed scenarios plus a
// randomized run against a queue-based reference of the output slot.
module tb_riscv_demux5;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid;
    logic [2:0]  sel;
    logic [63:0] din;
    logic        ready;
    logic [63:0] out0, out1, out2, out3, out4;
    logic [4:0]  ov;
    logic [4:0]  rdy;
    logic        err;
    logic [7:0]  cnt;
    logic [63:0] outs [5];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  s;
        logic [63:0] d;
    } ent_t;

    ent_t mq[$];
    bit   m_err;
    int   m_cnt;

    always #5 clk = ~clk;

    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;
    assign outs[4] = out4;

    riscv_demux5 #(.WIDTH(64)) dut (
        .i_riscv_demux5_clk      (clk),
        .i_riscv_demux5_rst      (rst),
        .i_riscv_demux5_flush    (flush),
        .i_riscv_demux5_valid    (valid),
        .i_riscv_demux5_sel      (sel),
        .i_riscv_demux5_in       (din),
        .o_riscv_demux5_ready    (ready),
        .o_riscv_demux5_out0     (out0),
        .o_riscv_demux5_out1     (out1),
        .o_riscv_demux5_out2     (out2),
        .o_riscv_demux5_out3     (out3),
        .o_riscv_demux5_out4     (out4),
        .o_riscv_demux5_valid    (ov),
        .i_riscv_demux5_ready    (rdy),
        .o_riscv_demux5_err      (err),
        .o_riscv_demux5_drop_cnt (cnt)
    );

    function automatic bit m_ready();
        if (flush) return 1'b0;
        if (mq.size() == 0) return 1'b1;
        return rdy[mq[0].s];
    endfunction

    function automatic logic [4:0] m_valid();
        if (mq.size() == 0) return 5'b0;
        return 5'b1 << mq[0].s;
    endfunction

    function automatic logic [63:0] m_out(int k);
        if (mq.size() != 0 && int'(mq[0].s) == k) return mq[0].d;
        return 64'h0;
    endfunction

    task automatic model_edge();
        bit acc;
        bit drain;
        acc   = valid && m_ready();
        drain = (mq.size() != 0) && rdy[mq[0].s];
        if (flush || drain) mq.delete();
        m_err = acc && (sel > 3'd4);
        if (m_err && m_cnt < 255) m_cnt++;
        if (acc && sel <= 3'd4) mq.push_back('{s: sel, d: din});
    endtask

    task automatic model_reset();
        mq.delete();
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        valid = 1'b0;
        sel = 3'd0;
        din = 64'h0;
        rdy = 5'h1F;
        model_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (ov !== 5'b0 || err !== 1'b0 || cnt !== 8'h0) begin
            fails++;
            $display("FAIL reset_state: ov=%b err=%b cnt=%0d want 0/0/0",
                     ov, err, cnt);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b want 1", ready);
        end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (outs[k] !== 64'h0) begin
                fails++;
                $display("FAIL reset_out%0d: got %h want 0", k, outs[k]);
            end
        end
    endtask

    task automatic test_single();
        rdy = 5'h1F;
        din = 64'hA5;
        sel = 3'd2;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tests++;
        if (ov !== 5'b00100) begin
            fails++;
            $display("FAIL single_valid: got %b want 00100", ov);
        end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (outs[k] !== (k == 2 ? 64'hA5 : 64'h0)) begin
                fails++;
                $display("FAIL single_out%0d: got %h", k, outs[k]);
            end
        end
        tick();
        tests++;
        if (ov !== 5'b0) begin
            fails++;
            $display("FAIL single_drain: got %b want 0", ov);
        end
    endtask

    task automatic test_backpressure();
        rdy = 5'b01111;
        din = 64'h11;
        sel = 3'd4;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (ov !== 5'b10000 || out4 !== 64'h11 || ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: ov=%b out4=%h rdy=%b want 10000/11/0",
                         i, ov, out4, ready);
            end
            tick();
        end
        rdy = 5'h1F;
        #1;
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_ready: got %b want 1", ready);
        end
        tick();
        tests++;
        if (ov !== 5'b0) begin
            fails++;
            $display("FAIL bp_drain: got %b want 0", ov);
        end
    endtask

    task automatic test_stream();
        rdy = 5'h1F;
        for (int k = 0; k < 5; k++) begin
            sel = 3'(k);
            din = 64'(k + 1);
            valid = 1'b1;
            #1;
            tests++;
            if (ready !== 1'b1) begin
                fails++;
                $display("FAIL stream_ready%0d: got %b want 1", k, ready);
            end
            tick();
            tests++;
            if (ov !== (5'b1 << k) || outs[k] !== 64'(k + 1)) begin
                fails++;
                $display("FAIL stream_ch%0d: ov=%b data=%h want %b/%0d",
                         k, ov, outs[k], 5'b1 << k, k + 1);
            end
        end
        valid = 1'b0;
        tick();
        tests++;
        if (ov !== 5'b0) begin
            fails++;
            $display("FAIL stream_drain: got %b want 0", ov);
        end
    endtask

    task automatic test_illegal();
        int want;
        rdy = 5'h1F;
        sel = 3'd6;
        valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            din = {$urandom, $urandom};
            tick();
            want = (i + 1 > 255) ? 255 : i + 1;
            tests++;
            if (ov !== 5'b0 || err !== 1'b1 || cnt !== 8'(want)) begin
                fails++;
                $display("FAIL illegal%0d: ov=%b err=%b cnt=%0d want 0/1/%0d",
                         i, ov, err, cnt, want);
            end
        end
        valid = 1'b0;
        tick();
        tests++;
        if (err !== 1'b0 || cnt !== 8'hFF) begin
            fails++;
            $display("FAIL illegal_hold: err=%b cnt=%0d want 0/255", err, cnt);
        end
    endtask

    task automatic test_flush();
        rdy = 5'b11101;
        sel = 3'd1;
        din = 64'h77;
        valid = 1'b1;
        tick();
        tests++;
        if (ov !== 5'b00010 || out1 !== 64'h77) begin
            fails++;
            $display("FAIL flush_fill: ov=%b out1=%h want 00010/77", ov, out1);
        end
        flush = 1'b1;
        sel = 3'd3;
        din = 64'h99;
        #1;
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_ready: got %b want 0", ready);
        end
        tick();
        flush = 1'b0;
        valid = 1'b0;
        tests++;
        if (ov !== 5'b0 || out1 !== 64'h0 || err !== 1'b0 || cnt !== 8'hFF) begin
            fails++;
            $display("FAIL flush_empty: ov=%b out1=%h err=%b cnt=%0d",
                     ov, out1, err, cnt);
        end
        tick();
        tests++;
        if (ov !== 5'b0 || out3 !== 64'h0) begin
            fails++;
            $display("FAIL flush_noaccept: ov=%b out3=%h want 0/0", ov, out3);
        end
    endtask

    task automatic test_async_reset();
        rdy = 5'b00000;
        sel = 3'd3;
        din = 64'hFF;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tests++;
        if (ov !== 5'b01000 || out3 !== 64'hFF || cnt !== 8'hFF) begin
            fails++;
            $display("FAIL areset_pre: ov=%b out3=%h cnt=%0d", ov, out3, cnt);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (ov !== 5'b0 || out3 !== 64'h0 || err !== 1'b0 || cnt !== 8'h0) begin
            fails++;
            $display("FAIL areset_now: ov=%b out3=%h err=%b cnt=%0d want 0",
                     ov, out3, err, cnt);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        rdy = 5'h1F;
        #1;
        tests++;
        if (ready !== 1'b1 || ov !== 5'b0) begin
            fails++;
            $display("FAIL areset_post: ready=%b ov=%b want 1/0", ready, ov);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            valid = ($urandom_range(0, 3) != 0);
            sel   = 3'($urandom_range(0, 7));
            din   = {$urandom, $urandom};
            rdy   = 5'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            #1;
            tests++;
            if (ready !== m_ready() || ov !== m_valid()
                || err !== m_err || cnt !== 8'(m_cnt)) begin
                fails++;
                $display("FAIL rand%0d: rdy=%b ov=%b err=%b cnt=%0d want %b/%b/%b/%0d",
                         i, ready, ov, err, cnt, m_ready(), m_valid(), m_err, m_cnt);
            end
            for (int k = 0; k < 5; k++) begin
                tests++;
                if (outs[k] !== m_out(k)) begin
                    fails++;
                    $display("FAIL rand%0d_out%0d: got %h want %h",
                             i, k, outs[k], m_out(k));
                end
            end
            tick();
        end
        flush = 1'b0;
        valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_illegal();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
